// File: rtl/tinker_mem_pkg.sv
// Shared types and constants for the tinker memory-port arbiter.
package tinker_mem_pkg;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_t;

    localparam int FETCH_W = 32;

endpackage

// File: rtl/tinker_mem_arbiter_rr2.sv
// Two-way round-robin picker; req bit 0 is fetch, bit 1 is data.
module arb_rr2
    import tinker_mem_pkg::*;
(
    input  logic [1:0] i_req,
    input  owner_t     i_last_owner,
    output logic [1:0] o_gnt,
    output owner_t     o_winner
);

    always_comb begin
        o_gnt    = 2'b00;
        o_winner = OWN_FETCH;
        if (i_req == 2'b11) begin
            // On a tie the requester that did not win last time goes first.
            o_winner = (i_last_owner == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
            o_gnt    = (i_last_owner == OWN_FETCH) ? 2'b10 : 2'b01;
        end else if (i_req == 2'b10) begin
            o_winner = OWN_DATA;
            o_gnt    = 2'b10;
        end else if (i_req == 2'b01) begin
            o_winner = OWN_FETCH;
            o_gnt    = 2'b01;
        end
    end

endmodule

// File: rtl/tinker_mem_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data.
//   state   | meaning
//   ST_IDLE | no transaction outstanding, a request may issue this cycle
//   ST_WAIT | one transaction outstanding, counting towards MEM_LAT
module tinker_mem_arbiter
    import tinker_mem_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    output logic [31:0]       fetch_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [63:0]       data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [63:0]       data_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    arb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    owner_t           r_owner;
    owner_t           r_last_owner;
    logic             r_is_store;

    logic [1:0] w_arb_gnt;
    owner_t     w_winner;
    logic       w_issue;
    logic       w_done;
    logic       w_sel_data;

    arb_rr2 u_rr2 (
        .i_req        ({data_req, fetch_req}),
        .i_last_owner (r_last_owner),
        .o_gnt        (w_arb_gnt),
        .o_winner     (w_winner)
    );

    // Reset gates the issue and completion strobes so it always wins.
    assign w_issue    = (r_state == ST_IDLE) && !reset && (fetch_req || data_req);
    assign w_done     = (r_state == ST_WAIT) && !reset && (r_cnt == CNT_W'(MEM_LAT));
    assign w_sel_data = (w_winner == OWN_DATA);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_owner      <= OWN_FETCH;
            r_last_owner <= OWN_FETCH;
            r_is_store   <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_issue) begin
                r_state      <= ST_WAIT;
                r_cnt        <= CNT_W'(1);
                r_owner      <= w_winner;
                r_last_owner <= w_winner;
                r_is_store   <= w_sel_data && data_we;
            end
        end else begin
            if (w_done) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign fetch_gnt = w_issue && w_arb_gnt[0];
    assign data_gnt  = w_issue && w_arb_gnt[1];
    assign mem_en    = w_issue;
    assign mem_we    = w_issue && w_sel_data && data_we;
    assign mem_addr  = !w_issue ? '0 : (w_sel_data ? data_addr : fetch_addr);
    assign mem_wdata = (w_issue && w_sel_data) ? data_wdata : '0;

    assign fetch_rvalid = w_done && (r_owner == OWN_FETCH);
    assign data_rvalid  = w_done && (r_owner == OWN_DATA);
    assign fetch_rdata  = fetch_rvalid ? mem_rdata[FETCH_W-1:0] : '0;
    assign data_rdata   = (data_rvalid && !r_is_store) ? mem_rdata : '0;

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// Bench for tinker_mem_arbiter at MEM_LAT=1 and MEM_LAT=3 against a cycle-count reference model.
module tb_tinker_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst          [2];
    logic        fetch_req    [2];
    logic [63:0] fetch_addr   [2];
    logic        fetch_gnt    [2];
    logic        fetch_rvalid [2];
    logic [31:0] fetch_rdata  [2];
    logic        data_req     [2];
    logic        data_we      [2];
    logic [63:0] data_addr    [2];
    logic [63:0] data_wdata   [2];
    logic        data_gnt     [2];
    logic        data_rvalid  [2];
    logic [63:0] data_rdata   [2];
    logic        mem_en       [2];
    logic        mem_we       [2];
    logic [63:0] mem_addr     [2];
    logic [63:0] mem_wdata    [2];
    logic [63:0] mem_rdata    [2];

    tinker_mem_arbiter #(.MEM_LAT(1), .ADDR_W(64)) u_lat1 (
        .clk(clk), .reset(rst[0]),
        .fetch_req(fetch_req[0]), .fetch_addr(fetch_addr[0]), .fetch_gnt(fetch_gnt[0]),
        .fetch_rvalid(fetch_rvalid[0]), .fetch_rdata(fetch_rdata[0]),
        .data_req(data_req[0]), .data_we(data_we[0]), .data_addr(data_addr[0]),
        .data_wdata(data_wdata[0]), .data_gnt(data_gnt[0]), .data_rvalid(data_rvalid[0]),
        .data_rdata(data_rdata[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    tinker_mem_arbiter #(.MEM_LAT(3), .ADDR_W(64)) u_lat3 (
        .clk(clk), .reset(rst[1]),
        .fetch_req(fetch_req[1]), .fetch_addr(fetch_addr[1]), .fetch_gnt(fetch_gnt[1]),
        .fetch_rvalid(fetch_rvalid[1]), .fetch_rdata(fetch_rdata[1]),
        .data_req(data_req[1]), .data_we(data_we[1]), .data_addr(data_addr[1]),
        .data_wdata(data_wdata[1]), .data_gnt(data_gnt[1]), .data_rvalid(data_rvalid[1]),
        .data_rdata(data_rdata[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit auto_drop = 1'b0;

    // Reference model: busy flag plus issue cycle; completion is issue + latency.
    int          m_busy [2];
    int          m_t0   [2];
    int          m_own  [2];
    int          m_last [2];
    bit          m_we   [2];
    logic [5:0]  e_ctl  [2];
    logic [63:0] e_addr [2];
    logic [63:0] e_wdata[2];
    logic [63:0] e_frd  [2];
    logic [63:0] e_drd  [2];
    int          e_issue[2];
    bit          e_done [2];

    int g_cyc [2][32];
    int g_who [2][32];
    int g_n   [2];
    int n_rv  [2];
    int s_f   [2];
    int s_d   [2];

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_expect(input int k);
        int   w;
        logic fg, dg, frv, drv, en, we;
        {fg, dg, frv, drv, en, we} = 6'b0;
        w = 0;
        e_addr[k] = '0; e_wdata[k] = '0; e_frd[k] = '0; e_drd[k] = '0;
        e_issue[k] = -1; e_done[k] = 1'b0;
        if (!rst[k]) begin
            if (m_busy[k] != 0) begin
                if (cyc - m_t0[k] == lat(k)) begin
                    e_done[k] = 1'b1;
                    if (m_own[k] == 0) begin
                        frv = 1'b1;
                        e_frd[k] = {32'h0, mem_rdata[k][31:0]};
                    end else begin
                        drv = 1'b1;
                        e_drd[k] = m_we[k] ? 64'h0 : mem_rdata[k];
                    end
                end
            end else if (fetch_req[k] || data_req[k]) begin
                if (fetch_req[k] && data_req[k]) w = 1 - m_last[k];
                else w = data_req[k] ? 1 : 0;
                e_issue[k] = w;
                en = 1'b1;
                if (w == 1) begin
                    dg = 1'b1; we = data_we[k];
                    e_addr[k] = data_addr[k]; e_wdata[k] = data_wdata[k];
                end else begin
                    fg = 1'b1;
                    e_addr[k] = fetch_addr[k];
                end
            end
        end
        e_ctl[k] = {fg, dg, frv, drv, en, we};
    endtask

    task automatic model_update(input int k);
        if (rst[k]) begin
            m_busy[k] = 0;
            m_last[k] = 0;
        end else if (e_done[k]) begin
            m_busy[k] = 0;
        end else if (e_issue[k] >= 0) begin
            m_busy[k] = 1;
            m_t0[k]   = cyc;
            m_own[k]  = e_issue[k];
            m_last[k] = e_issue[k];
            m_we[k]   = (e_issue[k] == 1) && data_we[k];
        end
    endtask

    task automatic cycle();
        string sfx;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sfx = $sformatf("_lat%0d", lat(k));
            model_expect(k);
            chk({"ctl", sfx}, {58'h0, fetch_gnt[k], data_gnt[k], fetch_rvalid[k],
                data_rvalid[k], mem_en[k], mem_we[k]}, {58'h0, e_ctl[k]});
            chk({"mem_addr", sfx}, mem_addr[k], e_addr[k]);
            chk({"mem_wdata", sfx}, mem_wdata[k], e_wdata[k]);
            chk({"fetch_rdata", sfx}, {32'h0, fetch_rdata[k]}, e_frd[k]);
            chk({"data_rdata", sfx}, data_rdata[k], e_drd[k]);
            if (fetch_gnt[k] && g_n[k] < 32) begin
                g_cyc[k][g_n[k]] = cyc; g_who[k][g_n[k]] = 0; g_n[k]++;
            end
            if (data_gnt[k] && g_n[k] < 32) begin
                g_cyc[k][g_n[k]] = cyc; g_who[k][g_n[k]] = 1; g_n[k]++;
            end
            if (fetch_rvalid[k] || data_rvalid[k]) n_rv[k]++;
            model_update(k);
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int k = 0; k < 2; k++) begin
            mem_rdata[k] = {$urandom, $urandom};
            if (auto_drop) begin
                if (e_ctl[k][5]) fetch_req[k] = 1'b0;
                if (e_ctl[k][4]) data_req[k]  = 1'b0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_log();
        for (int k = 0; k < 2; k++) begin
            g_n[k] = 0;
            n_rv[k] = 0;
            for (int i = 0; i < 32; i++) begin
                g_cyc[k][i] = -100; g_who[k][i] = -1;
            end
        end
    endtask

    task automatic do_reset();
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; fetch_req[k] = 1'b0; data_req[k] = 1'b0;
        end
        run(2);
        for (int k = 0; k < 2; k++) rst[k] = 1'b0;
    endtask

    task automatic set_data(input int k, input logic we, input logic [63:0] a, input logic [63:0] d);
        data_req[k] = 1'b1; data_we[k] = we; data_addr[k] = a; data_wdata[k] = d;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; fetch_req[k] = 1'b0; data_req[k] = 1'b0; data_we[k] = 1'b0;
            fetch_addr[k] = '0; data_addr[k] = '0; data_wdata[k] = '0; mem_rdata[k] = '0;
            m_busy[k] = 0; m_t0[k] = 0; m_own[k] = 0; m_last[k] = 0; m_we[k] = 1'b0;
            s_f[k] = 0; s_d[k] = 0;
        end
        clear_log();
        do_reset();
        run(1);

        // Single fetch to 0x2000, then an 8-byte store.
        auto_drop = 1'b1;
        for (int k = 0; k < 2; k++) begin
            fetch_req[k] = 1'b1; fetch_addr[k] = 64'h2000;
        end
        run(5);
        for (int k = 0; k < 2; k++) set_data(k, 1'b1, 64'h7FFF8, 64'h1122334455667788);
        run(5);

        // Both requesters held continuously straight after reset.
        do_reset();
        clear_log();
        auto_drop = 1'b0;
        for (int k = 0; k < 2; k++) begin
            fetch_req[k] = 1'b1; fetch_addr[k] = {$urandom, $urandom};
            set_data(k, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
        end
        run(18);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("tie_who%0d_lat%0d", i, lat(k)), g_who[k][i], (i % 2 == 0) ? 1 : 0);
            for (int i = 0; i < 3; i++)
                chk($sformatf("tie_gap%0d_lat%0d", i, lat(k)), g_cyc[k][i+1] - g_cyc[k][i], lat(k) + 1);
            for (int i = 0; i < 2; i++)
                chk($sformatf("tie_wait%0d_lat%0d", i, lat(k)),
                    64'((g_cyc[k][i+2] - g_cyc[k][i]) <= 2 * (lat(k) + 1)), 64'd1);
            fetch_req[k] = 1'b0; data_req[k] = 1'b0;
        end
        auto_drop = 1'b1;
        run(5);

        // Load at t0 with a fetch arriving in the rvalid cycle (mode 0) or pending from t1 (mode 1).
        for (int mode = 0; mode < 2; mode++) begin
            clear_log();
            for (int k = 0; k < 2; k++) set_data(k, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
            for (int rel = 0; rel < 6; rel++) begin
                for (int k = 0; k < 2; k++)
                    if ((mode == 0 && rel == lat(k)) || (mode == 1 && rel == 1)) begin
                        fetch_req[k] = 1'b1; fetch_addr[k] = {$urandom, $urandom};
                    end
                cycle();
            end
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("late_ngnt_m%0d_lat%0d", mode, lat(k)), g_n[k], 2);
                chk($sformatf("late_who_m%0d_lat%0d", mode, lat(k)), g_who[k][1], 0);
                chk($sformatf("late_gap_m%0d_lat%0d", mode, lat(k)), g_cyc[k][1] - g_cyc[k][0], lat(k) + 1);
            end
            run(4);
        end

        // Reset one cycle into a load: no response, then the first tie goes to data.
        for (int k = 0; k < 2; k++) set_data(k, 1'b0, {$urandom, $urandom}, 64'h0);
        run(1);
        clear_log();
        for (int k = 0; k < 2; k++) rst[k] = 1'b1;
        run(1);
        for (int k = 0; k < 2; k++) rst[k] = 1'b0;
        run(4);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("abort_rv_lat%0d", lat(k)), n_rv[k], 0);
            fetch_req[k] = 1'b1; fetch_addr[k] = {$urandom, $urandom};
            set_data(k, 1'b1, {$urandom, $urandom}, {$urandom, $urandom});
        end
        clear_log();
        run(1);
        for (int k = 0; k < 2; k++)
            chk($sformatf("post_rst_tie_lat%0d", lat(k)), g_who[k][0], 1);
        run(12);

        // Randomised traffic obeying the requester contract, with occasional resets.
        auto_drop = 1'b0;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            s_f[k] = 0; s_d[k] = 0;
        end
        for (int it = 0; it < 3000; it++) begin
            for (int k = 0; k < 2; k++) begin
                rst[k] = ($urandom_range(0, 99) == 0);
                if (s_f[k] == 0 && $urandom_range(0, 2) == 0) begin
                    s_f[k] = 1; fetch_req[k] = 1'b1; fetch_addr[k] = {$urandom, $urandom};
                end
                if (s_d[k] == 0 && $urandom_range(0, 2) == 0) begin
                    s_d[k] = 1;
                    set_data(k, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
                end
            end
            cycle();
            for (int k = 0; k < 2; k++) begin
                if (rst[k]) begin
                    s_f[k] = 0; s_d[k] = 0; fetch_req[k] = 1'b0; data_req[k] = 1'b0;
                end else begin
                    if (s_f[k] == 1 && e_ctl[k][5]) begin s_f[k] = 2; fetch_req[k] = 1'b0; end
                    else if (s_f[k] == 2 && e_ctl[k][3]) s_f[k] = 0;
                    if (s_d[k] == 1 && e_ctl[k][4]) begin s_d[k] = 2; data_req[k] = 1'b0; end
                    else if (s_d[k] == 2 && e_ctl[k][2]) s_d[k] = 0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
